// File: rtl/gp_register_file_if.sv
// Bus bundle for gp_register_file: load/modify/read controls, read data and flags.
// Shadow-bank signals exist only when REGFILE_SHADOW_EN is defined.
interface gp_register_file_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned SEL_WIDTH  = $clog2(NUM_REGS)
);
  logic                           load;
  logic [SEL_WIDTH-1:0]           load_sel;
  logic [DATA_WIDTH-1:0]          bus_in;
  logic                           inc;
  logic                           dec;
  logic [SEL_WIDTH-1:0]           mod_sel;
  logic [SEL_WIDTH-1:0]           rd_sel_a;
  logic [SEL_WIDTH-1:0]           rd_sel_b;
  logic [DATA_WIDTH-1:0]          rd_data_a;
  logic [DATA_WIDTH-1:0]          rd_data_b;
  logic [NUM_REGS*DATA_WIDTH-1:0] latched_data;
  logic                           zero_flag;
  logic                           wrap_flag;
`ifdef REGFILE_SHADOW_EN
  logic                           shadow_swap;
  logic                           shadow_active;
`endif

  modport master (
`ifdef REGFILE_SHADOW_EN
    output shadow_swap,
    input  shadow_active,
`endif
    output load, load_sel, bus_in, inc, dec, mod_sel, rd_sel_a, rd_sel_b,
    input  rd_data_a, rd_data_b, latched_data, zero_flag, wrap_flag
  );

  modport slave (
`ifdef REGFILE_SHADOW_EN
    input  shadow_swap,
    output shadow_active,
`endif
    input  load, load_sel, bus_in, inc, dec, mod_sel, rd_sel_a, rd_sel_b,
    output rd_data_a, rd_data_b, latched_data, zero_flag, wrap_flag
  );
endinterface

// File: rtl/gp_register_file.sv
// Parametrised general-purpose register bank with load, inc/dec and two read ports.
// Define REGFILE_SHADOW_EN to add a second (shadow) bank toggled by shadow_swap.
module gp_register_file #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           NUM_REGS    = 4,
  parameter int unsigned           SEL_WIDTH   = $clog2(NUM_REGS),
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input logic               clk,
  input logic               reset,
  gp_register_file_if.slave rf
);

`ifdef REGFILE_SHADOW_EN
  localparam int unsigned NUM_BANKS = 2;
`else
  localparam int unsigned NUM_BANKS = 1;
`endif
  localparam logic [SEL_WIDTH:0] NUM_REGS_W = (SEL_WIDTH + 1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS][NUM_REGS];
  logic [DATA_WIDTH-1:0] bank_d [NUM_BANKS][NUM_REGS];
  logic [DATA_WIDTH-1:0] cur    [NUM_REGS];
  logic                  zero_q, zero_d;
  logic                  wrap_q, wrap_d;
  logic                  bank_sel;
  logic                  load_ok, mod_ok, mod_wrap;
  logic [DATA_WIDTH-1:0] mod_old, mod_new;

`ifdef REGFILE_SHADOW_EN
  logic shadow_active_q, shadow_active_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) shadow_active_q <= 1'b0;
    else       shadow_active_q <= shadow_active_d;
  end

  // Same-edge ops still target the bank that was active before the toggle.
  assign shadow_active_d  = shadow_active_q ^ rf.shadow_swap;
  assign bank_sel         = shadow_active_q;
  assign rf.shadow_active = shadow_active_q;
`else
  assign bank_sel = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cur[i] = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (1'(b) == bank_sel) cur[i] = bank_q[b][i];
      end
    end
  end

  always_comb begin
    bank_d  = bank_q;
    zero_d  = zero_q;
    wrap_d  = 1'b0;
    mod_old = '0;
    load_ok = rf.load && ({1'b0, rf.load_sel} < NUM_REGS_W);
    // A load on the same register overrides the inc/dec entirely, flags included.
    mod_ok  = (rf.inc ^ rf.dec) && ({1'b0, rf.mod_sel} < NUM_REGS_W) &&
              !(load_ok && (rf.load_sel == rf.mod_sel));
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rf.mod_sel == SEL_WIDTH'(i)) mod_old = cur[i];
    end
    mod_new  = rf.inc ? mod_old + 1'b1 : mod_old - 1'b1;
    mod_wrap = rf.inc ? (mod_old == '1) : (mod_old == '0);
    if (mod_ok) begin
      zero_d = (mod_new == '0);
      wrap_d = mod_wrap;
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (1'(b) == bank_sel) begin
          if (load_ok && rf.load_sel == SEL_WIDTH'(i))     bank_d[b][i] = rf.bus_in;
          else if (mod_ok && rf.mod_sel == SEL_WIDTH'(i))  bank_d[b][i] = mod_new;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int i = 0; i < NUM_REGS; i++) bank_q[b][i] <= RESET_VALUE;
      end
      zero_q <= (RESET_VALUE == '0);
      wrap_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
      zero_q <= zero_d;
      wrap_q <= wrap_d;
    end
  end

  // Out-of-range selects match no entry and read back as zero.
  always_comb begin
    rf.rd_data_a    = '0;
    rf.rd_data_b    = '0;
    rf.latched_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rf.rd_sel_a == SEL_WIDTH'(i)) rf.rd_data_a = cur[i];
      if (rf.rd_sel_b == SEL_WIDTH'(i)) rf.rd_data_b = cur[i];
      rf.latched_data[i*DATA_WIDTH +: DATA_WIDTH] = cur[i];
    end
  end

  assign rf.zero_flag = zero_q;
  assign rf.wrap_flag = wrap_q;

endmodule
